// File: rtl/barrelshifter_pipe.sv
// ---------------------------------------------------------------------------
// barrelshifter_pipe
//
// Pipelined, parametrised barrel shifter. It sits between the operand
// register file and the ALU result mux and accepts one op per cycle.
//
// A D_SIZE-bit operand is shifted or rotated by 0..D_SIZE-1 positions through
// L = $clog2(D_SIZE) registered mux stages. Stage k moves the word by 2^k
// places when bit k of the shift amount is set. Each stage register carries:
//   - the partial result,
//   - the remaining op/shift-amount bits,
//   - a valid bit,
//   - the running flag accumulators (when flags are built in).
//
// The pipeline uses one global stall:
//   adv = !valid_out || ready_in
// When adv is low, every stage holds its contents. As a result, ops leave in
// issue order with a fixed latency of L cycles whenever no stall occurs.
//
// Parameters
//   D_SIZE     data width; a power of two and at least 4
//
// Ports
//   clk_in     clock; all registers update on the rising edge
//   rst_in     synchronous reset, active-high; clears every stage
//   valid_in   x_in/s_in/op_in carry an op this cycle
//   ready_out  block accepts an op this cycle
//   x_in       operand
//   s_in       shift amount, unsigned, 0..D_SIZE-1
//   op_in      000 LSR, 001 ASR, 01x ROR, 100 LSL, 101 ASL, 11x ROL
//   valid_out  y_out and the flags hold a result
//   ready_in   downstream takes the result this cycle
//   y_out      shifted/rotated result
//   zf_out     result is zero
//   vf_out     ASL changed the signed value
//   cf_out     last bit that left the word (0 when s == 0)
//
// Configuration macro
//   BARRELSHIFTER_FLAGS_EN
//     defined:   zf/vf/cf are accumulated stage by stage and registered
//                with the data.
//     undefined: no flag hardware is built; zf_out, vf_out and cf_out are
//                tied to 0. Data and handshake behaviour are unchanged.
// ---------------------------------------------------------------------------
module barrelshifter_pipe #(
  parameter  int D_SIZE = 8,
  localparam int L      = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [D_SIZE-1:0] x_in,
  input  logic [L-1:0]      s_in,
  input  logic [2:0]        op_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out,
  output logic              cf_out
);

  // The whole pipeline moves together. It only stalls when the output stage
  // holds a result that downstream refuses. Bubbles are never squeezed out,
  // so one global enable is enough to keep the ops in order.
  logic adv;

  assign adv       = !valid_out || ready_in;
  assign ready_out = adv && !rst_in;

  for (genvar k = 0; k < L; k++) begin : g_stage
    // Distance this stage moves the word.
    localparam int SH = 1 << k;
    // Shift-amount bits still to be consumed, from this stage onwards.
    localparam int SW = L - k;

    logic [D_SIZE-1:0] d_cur;
    logic [2:0]        op_cur;
    logic [SW-1:0]     s_cur;
    logic              v_cur;
`ifdef BARRELSHIFTER_FLAGS_EN
    logic              cf_cur;
    logic              vf_cur;
`endif

    // Stage 0 takes the op straight from the ports. Later stages take it from
    // the previous stage's registers. The shift amount is consumed one bit
    // per stage, so the bit that steers this stage is always bit 0 here.
    if (k == 0) begin : g_src
      assign d_cur  = x_in;
      assign op_cur = op_in;
      assign s_cur  = s_in;
      assign v_cur  = valid_in && ready_out;
`ifdef BARRELSHIFTER_FLAGS_EN
      assign cf_cur = 1'b0;
      assign vf_cur = 1'b0;
`endif
    end else begin : g_src
      assign d_cur  = g_stage[k-1].d_q;
      assign op_cur = g_stage[k-1].g_fwd.op_q;
      assign s_cur  = g_stage[k-1].g_fwd.s_q;
      assign v_cur  = g_stage[k-1].v_q;
`ifdef BARRELSHIFTER_FLAGS_EN
      assign cf_cur = g_stage[k-1].cf_q;
      assign vf_cur = g_stage[k-1].vf_q;
`endif
    end

    logic              do_shift;
    logic [D_SIZE-1:0] shifted;
    logic [D_SIZE-1:0] d_next;

    assign do_shift = s_cur[0];

    // Build the word moved by SH places, one output bit at a time.
    //   op[2] selects the direction (0 = right, 1 = left).
    //   op[1] selects rotation. It takes priority over op[0], so 01x and 11x
    //         both rotate.
    // The source index is taken modulo D_SIZE. For rotates this is exactly
    // the wrap-around bit. For plain shifts, the positions that would wrap are
    // replaced by the fill value:
    //   - sign bit for ASR,
    //   - zero for LSR, LSL and ASL.
    always_comb begin
      shifted = '0;
      for (int i = 0; i < D_SIZE; i++) begin
        if (!op_cur[2]) begin
          if ((i + SH < D_SIZE) || op_cur[1]) begin
            shifted[i] = d_cur[(i + SH) % D_SIZE];
          end else if (op_cur[0]) begin
            shifted[i] = d_cur[D_SIZE-1];
          end else begin
            shifted[i] = 1'b0;
          end
        end else begin
          if ((i >= SH) || op_cur[1]) begin
            shifted[i] = d_cur[(i + D_SIZE - SH) % D_SIZE];
          end else begin
            shifted[i] = 1'b0;
          end
        end
      end
    end

    assign d_next = do_shift ? shifted : d_cur;

    logic [D_SIZE-1:0] d_q;
    logic              v_q;

    // Data and valid for this stage. Reset flushes everything in flight;
    // a stall freezes the stage as a whole.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        d_q <= '0;
        v_q <= 1'b0;
      end else if (adv) begin
        d_q <= d_next;
        v_q <= v_cur;
      end
    end

    // Only stages that feed a further stage need to carry the op and the
    // unconsumed shift-amount bits. The last stage has no use for them.
    if (k < L - 1) begin : g_fwd
      logic [2:0]    op_q;
      logic [SW-2:0] s_q;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          op_q <= '0;
          s_q  <= '0;
        end else if (adv) begin
          op_q <= op_cur;
          s_q  <= s_cur[SW-1:1];
        end
      end
    end

`ifdef BARRELSHIFTER_FLAGS_EN
    logic [SH:0] top_bits;
    logic        top_mixed;
    logic        cf_step;
    logic        cf_next;
    logic        vf_next;

    // For ASL, this stage pushes out the top SH bits. The bit just below them
    // becomes the new sign. If those SH+1 bits are not all equal, the signed
    // value is lost. The windows checked by successive stages overlap by one
    // bit, so OR-ing the per-stage results covers the whole original window.
    assign top_bits  = d_cur[D_SIZE-1 -: SH+1];
    assign top_mixed = !((top_bits == '0) || (&top_bits));

    // The last bit to leave the word is the same bit for shifts and rotates:
    //   right: the bit that was at position SH-1 (the new MSB for ROR);
    //   left:  the bit that was at position D_SIZE-SH (the new LSB for ROL).
    // A stage that does not shift passes the carry through untouched.
    assign cf_step = op_cur[2] ? d_cur[D_SIZE-SH] : d_cur[SH-1];
    assign cf_next = do_shift ? cf_step : cf_cur;
    assign vf_next = vf_cur || (do_shift && (op_cur == 3'b101) && top_mixed);

    logic cf_q;
    logic vf_q;

    // Carry and overflow accumulators travel alongside the data.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        cf_q <= 1'b0;
        vf_q <= 1'b0;
      end else if (adv) begin
        cf_q <= cf_next;
        vf_q <= vf_next;
      end
    end

    // The zero flag depends only on the final word, so it exists only in the
    // last stage.
    if (k == L - 1) begin : g_zero
      logic zf_q;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          zf_q <= 1'b0;
        end else if (adv) begin
          zf_q <= (d_next == '0);
        end
      end
    end
`endif
  end

  assign y_out     = g_stage[L-1].d_q;
  assign valid_out = g_stage[L-1].v_q;

`ifdef BARRELSHIFTER_FLAGS_EN
  assign zf_out = g_stage[L-1].g_zero.zf_q;
  assign vf_out = g_stage[L-1].vf_q;
  assign cf_out = g_stage[L-1].cf_q;
`else
  assign zf_out = 1'b0;
  assign vf_out = 1'b0;
  assign cf_out = 1'b0;
`endif

endmodule

// File: tb/tb_barrelshifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrelshifter_pipe
//
// Self-checking bench for barrelshifter_pipe with D_SIZE = 8.
//
// Results are compared against:
//   - a table of known answers, and
//   - an arithmetic reference model.
// Expected ops wait in a queue in issue order.
//
// Flag expectations follow BARRELSHIFTER_FLAGS_EN. When the macro is absent,
// all three flags are expected to stay 0.
// ---------------------------------------------------------------------------
module tb_barrelshifter_pipe;

  localparam int D_SIZE = 8;
`ifdef BARRELSHIFTER_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] x_in;
  logic [2:0] s_in;
  logic [2:0] op_in;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] y_out;
  logic       zf_out;
  logic       vf_out;
  logic       cf_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] y;
    logic       zf;
    logic       vf;
    logic       cf;
    int         acc;
  } exp_t;

  barrelshifter_pipe #(.D_SIZE(D_SIZE)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x_in      (x_in),
    .s_in      (s_in),
    .op_in     (op_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .y_out     (y_out),
    .zf_out    (zf_out),
    .vf_out    (vf_out),
    .cf_out    (cf_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model built from the operation definitions:
  //   - rotates from a doubled word,
  //   - ASL overflow from whether the signed product leaves the 8-bit range.
  function automatic exp_t ref_model(input logic [7:0] x, input logic [2:0] s,
                                     input logic [2:0] op);
    exp_t              e;
    int                n;
    int                prod;
    logic signed [7:0] sx;
    logic [15:0]       w;
    n     = int'(s);
    sx    = x;
    e.acc = 0;
    e.zf  = 1'b0;
    e.vf  = 1'b0;
    e.cf  = 1'b0;
    case (op)
      3'b000:         e.y = x >> n;
      3'b001:         e.y = sx >>> n;
      3'b010, 3'b011: begin w = {x, x} >> n; e.y = w[7:0]; end
      3'b100, 3'b101: e.y = x << n;
      default:        begin w = {x, x} << n; e.y = w[15:8]; end
    endcase
    if (n != 0) begin
      if (op[2] == 1'b0) e.cf = op[1] ? e.y[7] : x[n-1];
      else               e.cf = op[1] ? e.y[0] : x[8-n];
    end
    if (op == 3'b101) begin
      prod = int'(sx) * (1 << n);
      e.vf = (prod > 127) || (prod < -128);
    end
    e.zf = (e.y == 8'h00);
    if (!FLAGS_ON) begin
      e.zf = 1'b0;
      e.vf = 1'b0;
      e.cf = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] x, input logic [2:0] s,
                       input logic [2:0] op, input logic rdy);
    valid_in = v;
    x_in     = x;
    s_in     = s;
    op_in    = op;
    ready_in = rdy;
  endtask

  // Start a new cycle: inputs change just after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    step();
    step();
    @(negedge clk_in);
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready_low: got %b expected 0", ready_out);
    end
    step();
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", valid_out);
    end
    checks++;
    if (y_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_y: got %h expected 00", y_out);
    end
    checks++;
    if ({zf_out, vf_out, cf_out} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {zf_out, vf_out, cf_out});
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready_high: got %b expected 1", ready_out);
    end
  endtask

  // Known answers, one op per cycle with ready_in held high. Each result must
  // appear exactly three cycles after it was accepted.
  task automatic test_ops();
    logic [7:0] tx [14] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'hE0,
                            8'h40, 8'h01, 8'h96, 8'h96, 8'h80, 8'h81, 8'h0F};
    logic [2:0] ts [14] = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd1, 3'd0, 3'd2,
                            3'd1, 3'd1, 3'd3, 3'd1, 3'd7, 3'd7, 3'd4};
    logic [2:0] to [14] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b101,
                            3'b101, 3'b000, 3'b111, 3'b011, 3'b001, 3'b100, 3'b101};
    logic [7:0] ty [14] = '{8'h12, 8'hF2, 8'h69, 8'h2C, 8'h2C, 8'h96, 8'h80,
                            8'h80, 8'h00, 8'hB4, 8'h4B, 8'hFF, 8'h80, 8'hF0};
    // Flags packed as {zf, vf, cf}.
    logic [2:0] tf [14] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b011, 3'b000, 3'b001,
                            3'b010, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
    int         pend_idx [$];
    int         pend_acc [$];
    int         idx;
    int         j;
    int         a;
    int         budget;
    idx    = 0;
    budget = 0;
    while ((idx < 14 || pend_idx.size() != 0) && budget < 40) begin
      budget++;
      step();
      if (idx < 14) drive(1'b1, tx[idx], ts[idx], to[idx], 1'b1);
      else          drive(1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
      @(negedge clk_in);
      if (valid_in) begin
        checks++;
        if (ready_out !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ops_ready: got %b expected 1", ready_out);
        end else begin
          pend_idx.push_back(idx);
          pend_acc.push_back(cyc);
          idx++;
        end
      end
      if (valid_out === 1'b1) begin
        if (pend_idx.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ops_spurious: got valid_out 1 expected 0");
        end else begin
          j = pend_idx.pop_front();
          a = pend_acc.pop_front();
          checks++;
          if (y_out !== ty[j]) begin
            errors++;
            $display("[TB] FAIL ops_y[%0d]: got %h expected %h", j, y_out, ty[j]);
          end
          checks++;
          if ({zf_out, vf_out, cf_out} !== (tf[j] & {3{FLAGS_ON}})) begin
            errors++;
            $display("[TB] FAIL ops_flags[%0d]: got %b expected %b", j,
                     {zf_out, vf_out, cf_out}, tf[j] & {3{FLAGS_ON}});
          end
          checks++;
          if (cyc != a + 3) begin
            errors++;
            $display("[TB] FAIL ops_latency[%0d]: got %0d expected 3", j, cyc - a);
          end
        end
      end
    end
    checks++;
    if (idx != 14 || pend_idx.size() != 0) begin
      errors++;
      $display("[TB] FAIL ops_complete: got %0d issued, %0d pending expected 14 issued, 0 pending",
               idx, pend_idx.size());
    end
  endtask

  // Five back-to-back ops while ready_in is low in cycles 3..6.
  task automatic test_backpressure();
    logic [7:0] bx [5];
    logic [2:0] bs [5];
    logic [2:0] bo [5];
    exp_t       q [$];
    exp_t       e;
    int         sent;
    int         recv;
    int         t;
    int         stalls;
    logic       held;
    logic [7:0] held_y;
    logic       rdy;
    for (int i = 0; i < 5; i++) begin
      bx[i] = 8'($urandom_range(1, 255));
      bs[i] = 3'($urandom_range(1, 7));
      bo[i] = 3'($urandom_range(0, 7));
    end
    sent   = 0;
    recv   = 0;
    t      = 0;
    stalls = 0;
    held   = 1'b0;
    held_y = 8'h00;
    while (recv < 5 && t < 40) begin
      step();
      t++;
      rdy = !(t >= 3 && t <= 6);
      if (sent < 5) drive(1'b1, bx[sent], bs[sent], bo[sent], rdy);
      else          drive(1'b0, 8'h00, 3'd0, 3'd0, rdy);
      @(negedge clk_in);
      if (valid_out === 1'b1 && !ready_in) begin
        stalls++;
        checks++;
        if (ready_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_ready_low: got %b expected 0", ready_out);
        end
        if (held) begin
          checks++;
          if (y_out !== held_y) begin
            errors++;
            $display("[TB] FAIL bp_hold_y: got %h expected %h", y_out, held_y);
          end
        end
        held   = 1'b1;
        held_y = y_out;
      end else begin
        held = 1'b0;
      end
      if (valid_in && ready_out === 1'b1) begin
        q.push_back(ref_model(bx[sent], bs[sent], bo[sent]));
        sent++;
      end
      if (valid_out === 1'b1 && ready_in) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_duplicate: got extra result %h expected none", y_out);
        end else begin
          e = q.pop_front();
          recv++;
          if (y_out !== e.y || {zf_out, vf_out, cf_out} !== {e.zf, e.vf, e.cf}) begin
            errors++;
            $display("[TB] FAIL bp_result[%0d]: got %h/%b expected %h/%b", recv, y_out,
                     {zf_out, vf_out, cf_out}, e.y, {e.zf, e.vf, e.cf});
          end
        end
      end
    end
    checks++;
    if (recv != 5 || q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d delivered expected 5", recv);
    end
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("[TB] FAIL bp_stall_cycles: got %0d expected 3", stalls);
    end
  endtask

  // Random valid_in and ready_in traffic, checked against the reference model.
  task automatic test_random();
    exp_t       q [$];
    exp_t       e;
    int         sent;
    int         recv;
    int         budget;
    logic       held;
    logic [7:0] held_y;
    logic [7:0] rx;
    logic [2:0] rs;
    logic [2:0] ro;
    sent   = 0;
    recv   = 0;
    budget = 0;
    held   = 1'b0;
    held_y = 8'h00;
    while ((sent < 10000 || q.size() != 0) && budget < 60000) begin
      budget++;
      step();
      rx = 8'($urandom);
      rs = 3'($urandom_range(0, 7));
      ro = 3'($urandom_range(0, 7));
      drive((sent < 10000) && ($urandom_range(0, 3) != 0), rx, rs, ro,
            $urandom_range(0, 3) != 0);
      @(negedge clk_in);
      if (held) begin
        checks++;
        if (valid_out !== 1'b1 || y_out !== held_y) begin
          errors++;
          $display("[TB] FAIL rnd_hold: got %b/%h expected 1/%h", valid_out, y_out, held_y);
        end
      end
      held   = (valid_out === 1'b1) && !ready_in;
      held_y = y_out;
      if (valid_in && ready_out === 1'b1) begin
        q.push_back(ref_model(rx, rs, ro));
        sent++;
      end
      if (valid_out === 1'b1 && ready_in) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rnd_duplicate: got extra result %h expected none", y_out);
        end else begin
          e = q.pop_front();
          recv++;
          if (y_out !== e.y || {zf_out, vf_out, cf_out} !== {e.zf, e.vf, e.cf}) begin
            errors++;
            $display("[TB] FAIL rnd_result[%0d]: got %h/%b expected %h/%b", recv, y_out,
                     {zf_out, vf_out, cf_out}, e.y, {e.zf, e.vf, e.cf});
          end
        end
      end
    end
    checks++;
    if (recv != 10000) begin
      errors++;
      $display("[TB] FAIL rnd_count: got %0d delivered expected 10000", recv);
    end
  endtask

  // Three ops in flight, then reset. The next op must come back cleanly.
  task automatic test_reset_inflight();
    int   a;
    logic got;
    step(); drive(1'b1, 8'hA5, 3'd0, 3'b110, 1'b1);
    step(); drive(1'b1, 8'h5A, 3'd0, 3'b110, 1'b1);
    step(); drive(1'b1, 8'hC3, 3'd0, 3'b110, 1'b1);
    step();
    rst_in = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    @(negedge clk_in);
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_fl_ready_low: got %b expected 0", ready_out);
    end
    step();
    rst_in = 1'b0;
    drive(1'b1, 8'h96, 3'd3, 3'b000, 1'b1);
    @(negedge clk_in);
    checks++;
    if (valid_out !== 1'b0 || y_out !== 8'h00 || {zf_out, vf_out, cf_out} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_fl_clear: got %b/%h/%b expected 0/00/000", valid_out, y_out,
               {zf_out, vf_out, cf_out});
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_fl_ready_high: got %b expected 1", ready_out);
    end
    a   = cyc;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      drive(1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
      @(negedge clk_in);
      if (valid_out === 1'b1) begin
        got = 1'b1;
        checks++;
        if (cyc != a + 3 || y_out !== 8'h12 ||
            {zf_out, vf_out, cf_out} !== (3'b001 & {3{FLAGS_ON}})) begin
          errors++;
          $display("[TB] FAIL rst_fl_first_op: got lat %0d %h/%b expected lat 3 12/%b",
                   cyc - a, y_out, {zf_out, vf_out, cf_out}, 3'b001 & {3{FLAGS_ON}});
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL rst_fl_timeout: got no result expected one within 6 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
